// File: rtl/vga_raster_out.sv
// VGA raster timing generator with pixel-tick divider, sync/blank delay line
// matched to the pixel pipeline latency, and 3-3-2 to 8-8-8 colour expansion.
module vga_raster_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int PIPE_DLY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  RGBIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic        oVGA_HS,
    output logic        oVGA_VS,
    output logic        oVGA_BLANK_N,
    output logic [7:0]  oVGA_R,
    output logic [7:0]  oVGA_G,
    output logic [7:0]  oVGA_B
);

    // Sums are formed as int and only then narrowed, so totals up to 2047 never wrap.
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [2:0]  IDLE     = 3'b110; // {hs, vs, vis} while not displaying

    function automatic logic [7:0] expand3(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    function automatic logic [7:0] expand2(input logic [1:0] c);
        return {4{c}};
    endfunction

    logic        tk_s;
    logic [10:0] px_q, px_d;
    logic [10:0] py_q, py_d;
    logic        sof_q, sof_d;
    logic [2:0]  raw_s;
    logic [2:0]  dly_s;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        bn_q, bn_d;
    logic [7:0]  r_q, r_d;
    logic [7:0]  g_q, g_d;
    logic [7:0]  b_q, b_d;

    generate
        if (CLK_DIV == 1) begin : g_nodiv
            assign tk_s = 1'b1;
        end else begin : g_div
            logic div_q;
            // Pixel tick divider: tick on every second clk
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    div_q <= 1'b0;
                end else begin
                    div_q <= ~div_q;
                end
            end
            assign tk_s = div_q;
        end
    endgenerate

    // Counter next state; startOfFrame is armed only by a real frame wrap
    always_comb begin
        sof_d = 1'b0;
        if (tk_s) begin
            if (px_q == H_LAST) begin
                px_d = 11'd0;
                if (py_q == V_LAST) begin
                    py_d  = 11'd0;
                    sof_d = 1'b1;
                end else begin
                    py_d = py_q + 11'd1;
                end
            end else begin
                px_d = px_q + 11'd1;
                py_d = py_q;
            end
        end else begin
            px_d = px_q;
            py_d = py_q;
        end
    end

    // Raster counter and frame-start registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px_q  <= 11'd0;
            py_q  <= 11'd0;
            sof_q <= 1'b0;
        end else begin
            px_q  <= px_d;
            py_q  <= py_d;
            sof_q <= sof_d;
        end
    end

    // Undelayed sync and visible flags decoded from the counters
    always_comb begin
        raw_s[2] = ~((px_q >= HS_FIRST) && (px_q <= HS_LAST));
        raw_s[1] = ~((py_q >= VS_FIRST) && (py_q <= VS_LAST));
        raw_s[0] = (px_q < H_VIS) && (py_q < V_VIS);
    end

    generate
        if (PIPE_DLY == 0) begin : g_nodly
            assign dly_s = raw_s;
        end else begin : g_dly
            logic [2:0] dly_q [PIPE_DLY];
            // Delay line matching the external pixel pipeline latency
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_DLY; i++) begin
                        dly_q[i] <= IDLE;
                    end
                end else begin
                    dly_q[0] <= raw_s;
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end
            assign dly_s = dly_q[PIPE_DLY-1];
        end
    endgenerate

    // Output stage next state: colour forced to black outside the visible area
    always_comb begin
        hs_d = dly_s[2];
        vs_d = dly_s[1];
        bn_d = dly_s[0];
        if (dly_s[0]) begin
            r_d = expand3(RGBIn[7:5]);
            g_d = expand3(RGBIn[4:2]);
            b_d = expand2(RGBIn[1:0]);
        end else begin
            r_d = 8'd0;
            g_d = 8'd0;
            b_d = 8'd0;
        end
    end

    // Output register shared by syncs, blank and colour keeps them aligned
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            bn_q <= 1'b0;
            r_q  <= 8'd0;
            g_q  <= 8'd0;
            b_q  <= 8'd0;
        end else begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            bn_q <= bn_d;
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
        end
    end

    assign pixelX       = px_q;
    assign pixelY       = py_q;
    assign startOfFrame = sof_q;
    assign oVGA_HS      = hs_q;
    assign oVGA_VS      = vs_q;
    assign oVGA_BLANK_N = bn_q;
    assign oVGA_R       = r_q;
    assign oVGA_G       = g_q;
    assign oVGA_B       = b_q;

endmodule

// File: tb/tb_vga_raster_out.sv
// Directed bench for vga_raster_out: default 640x480 timing plus small
// raster configurations so whole frames fit in a short run.
module tb_vga_raster_out;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] rgb = 8'h00;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // u_def: default timing
    logic [10:0] d_x, d_y;
    logic d_sof, d_hs, d_vs, d_bn;
    logic [7:0] d_r, d_g, d_b;
    // u_sm: 16x8 raster, CLK_DIV=2, PIPE_DLY=1
    logic [10:0] s_x, s_y;
    logic s_sof, s_hs, s_vs, s_bn;
    logic [7:0] s_r, s_g, s_b;
    // u_p0 / u_p3: 10x5 raster, CLK_DIV=1, PIPE_DLY 0 and 3
    logic [10:0] a_x, a_y, b_x, b_y;
    logic a_sof, a_hs, a_vs, a_bn, b_sof, b_hs, b_vs, b_bn;
    logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;

    vga_raster_out u_def (
        .clk(clk), .reset(reset), .RGBIn(rgb),
        .pixelX(d_x), .pixelY(d_y), .startOfFrame(d_sof),
        .oVGA_HS(d_hs), .oVGA_VS(d_vs), .oVGA_BLANK_N(d_bn),
        .oVGA_R(d_r), .oVGA_G(d_g), .oVGA_B(d_b)
    );

    vga_raster_out #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(2), .PIPE_DLY(1)
    ) u_sm (
        .clk(clk), .reset(reset), .RGBIn(rgb),
        .pixelX(s_x), .pixelY(s_y), .startOfFrame(s_sof),
        .oVGA_HS(s_hs), .oVGA_VS(s_vs), .oVGA_BLANK_N(s_bn),
        .oVGA_R(s_r), .oVGA_G(s_g), .oVGA_B(s_b)
    );

    vga_raster_out #(
        .H_ACTIVE(4), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .PIPE_DLY(0)
    ) u_p0 (
        .clk(clk), .reset(reset), .RGBIn(rgb),
        .pixelX(a_x), .pixelY(a_y), .startOfFrame(a_sof),
        .oVGA_HS(a_hs), .oVGA_VS(a_vs), .oVGA_BLANK_N(a_bn),
        .oVGA_R(a_r), .oVGA_G(a_g), .oVGA_B(a_b)
    );

    vga_raster_out #(
        .H_ACTIVE(4), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .PIPE_DLY(3)
    ) u_p3 (
        .clk(clk), .reset(reset), .RGBIn(rgb),
        .pixelX(b_x), .pixelY(b_y), .startOfFrame(b_sof),
        .oVGA_HS(b_hs), .oVGA_VS(b_vs), .oVGA_BLANK_N(b_bn),
        .oVGA_R(b_r), .oVGA_G(b_g), .oVGA_B(b_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until the selected DUT first shows (x,y); ok=0 if the budget runs out
    task automatic wait_xy(input int sel, input int x, input int y, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            case (sel)
                0:       ok = (int'(d_x) == x) && (int'(d_y) == y);
                1:       ok = (int'(s_x) == x) && (int'(s_y) == y);
                default: ok = (int'(a_x) == x) && (int'(a_y) == y);
            endcase
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rgb   = 8'hFF;
        repeat (3) tick();
        checks++;
        if ({d_x, d_y} !== 22'd0) begin errors++; $display("FAIL reset_xy got %0d,%0d want 0,0", d_x, d_y); end
        checks++;
        if ({d_hs, d_vs, d_bn, d_sof} !== 4'b1100) begin errors++; $display("FAIL reset_sync got hs/vs/bn/sof=%b want 1100", {d_hs, d_vs, d_bn, d_sof}); end
        checks++;
        if ({d_r, d_g, d_b} !== 24'h000000) begin errors++; $display("FAIL reset_rgb got %h want 000000", {d_r, d_g, d_b}); end
        checks++;
        if ({a_hs, a_vs, a_bn, a_sof, a_r, a_g, a_b, b_hs, b_vs, b_bn} !== {4'b1100, 24'h0, 3'b110}) begin
            errors++; $display("FAIL reset_small got a:%b%b%b%b %h b:%b%b%b want a:1100 000000 b:110",
                a_hs, a_vs, a_bn, a_sof, {a_r, a_g, a_b}, b_hs, b_vs, b_bn);
        end
    endtask

    task automatic test_first_tick();
        int bad;
        reset = 1'b0;
        rgb   = 8'h00;
        tick();
        checks++;
        if (d_x !== 11'd0 || a_x !== 11'd1) begin errors++; $display("FAIL first_edge got def x=%0d div1 x=%0d want 0,1", d_x, a_x); end
        tick();
        checks++;
        if (d_x !== 11'd1 || d_y !== 11'd0 || a_x !== 11'd2) begin
            errors++; $display("FAIL second_edge got def (%0d,%0d) div1 x=%0d want (1,0) 2", d_x, d_y, a_x);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (d_sof || s_sof || a_sof || b_sof || !d_hs) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL no_sof_after_reset got %0d bad clks want 0", bad); end
    endtask

    task automatic test_wrap();
        bit ok;
        int n;
        wait_xy(2, 9, 1, 100, ok);
        tick();
        checks++;
        if (!ok || a_x !== 11'd0 || a_y !== 11'd2 || a_sof !== 1'b0) begin
            errors++; $display("FAIL line_wrap got (%0d,%0d) sof=%b ok=%b want (0,2) sof=0", a_x, a_y, a_sof, ok);
        end
        wait_xy(2, 8, 2, 20, ok);
        checks++;
        if (!ok || a_hs !== 1'b0) begin errors++; $display("FAIL hs_low_small got %b ok=%b want 0", a_hs, ok); end
        tick();
        checks++;
        if (a_hs !== 1'b1) begin errors++; $display("FAIL hs_high_small got %b want 1", a_hs); end
        wait_xy(2, 1, 3, 50, ok);
        checks++;
        if (!ok || a_vs !== 1'b0) begin errors++; $display("FAIL vs_low_small got %b ok=%b want 0", a_vs, ok); end
        wait_xy(2, 1, 4, 50, ok);
        checks++;
        if (!ok || a_vs !== 1'b1) begin errors++; $display("FAIL vs_high_small got %b ok=%b want 1", a_vs, ok); end
        wait_xy(2, 9, 4, 50, ok);
        tick();
        checks++;
        if (!ok || a_x !== 11'd0 || a_y !== 11'd0 || a_sof !== 1'b1) begin
            errors++; $display("FAIL frame_wrap got (%0d,%0d) sof=%b ok=%b want (0,0) sof=1", a_x, a_y, a_sof, ok);
        end
        tick();
        checks++;
        if (a_sof !== 1'b0 || a_x !== 11'd1) begin errors++; $display("FAIL sof_width got sof=%b x=%0d want 0,1", a_sof, a_x); end
        n = 1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            n++;
            ok = a_sof;
        end
        checks++;
        if (!ok || n != 50) begin errors++; $display("FAIL sof_period_small got %0d ok=%b want 50", n, ok); end
    endtask

    task automatic test_pipe_lag();
        bit ok;
        wait_xy(2, 0, 0, 100, ok);
        checks++;
        if (!ok || a_bn !== 1'b0) begin errors++; $display("FAIL lag0_before got %b ok=%b want 0", a_bn, ok); end
        tick();
        checks++;
        if (a_bn !== 1'b1) begin errors++; $display("FAIL lag0_rise got %b want 1", a_bn); end
        tick();
        tick();
        checks++;
        if (b_bn !== 1'b0) begin errors++; $display("FAIL lag3_before got %b want 0", b_bn); end
        tick();
        checks++;
        if (b_bn !== 1'b1) begin errors++; $display("FAIL lag3_rise got %b want 1", b_bn); end
    endtask

    task automatic test_color();
        bit ok;
        rgb = 8'h00;
        wait_xy(0, 10, 10, 20000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL reach_10_10 got timeout want pixel (10,10)"); end
        tick();
        rgb = 8'hE3;
        tick();
        checks++;
        if ({d_bn, d_r, d_g, d_b} !== {1'b1, 24'hFF00FF}) begin
            errors++; $display("FAIL color_e3 got bn=%b rgb=%h want bn=1 rgb=ff00ff", d_bn, {d_r, d_g, d_b});
        end
        rgb = 8'h49;
        tick();
        checks++;
        if ({d_bn, d_r, d_g, d_b} !== {1'b1, 24'h494955}) begin
            errors++; $display("FAIL color_49 got bn=%b rgb=%h want bn=1 rgb=494955", d_bn, {d_r, d_g, d_b});
        end
        rgb = 8'h00;
    endtask

    task automatic test_blank();
        bit ok;
        int bad;
        rgb = 8'hFF;
        wait_xy(0, 640, 10, 2000, ok);
        tick();
        bad = 0;
        for (int i = 0; i < 320; i++) begin
            tick();
            if (d_bn !== 1'b0 || {d_r, d_g, d_b} !== 24'h0) bad++;
        end
        checks++;
        if (!ok || bad != 0) begin errors++; $display("FAIL hblank_black got %0d bad clks ok=%b want 0", bad, ok); end
        tick();
        checks++;
        if ({d_bn, d_r, d_g, d_b} !== {1'b1, 24'hFFFFFF}) begin
            errors++; $display("FAIL next_line_vis got bn=%b rgb=%h want bn=1 rgb=ffffff", d_bn, {d_r, d_g, d_b});
        end
    endtask

    task automatic test_hsync();
        int hs_low;
        int vs_low;
        hs_low = 0;
        vs_low = 0;
        for (int i = 0; i < 1600; i++) begin
            tick();
            if (!d_hs) hs_low++;
            if (!d_vs) vs_low++;
        end
        checks++;
        if (hs_low != 192 || vs_low != 0) begin errors++; $display("FAIL hs_per_line got hs=%0d vs=%0d want 192,0", hs_low, vs_low); end
    endtask

    task automatic test_frame();
        bit ok;
        int sof_cnt, sof_pos, hs_low, vs_low, bn_hi;
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            tick();
            ok = s_sof;
        end
        checks++;
        if (!ok || s_x !== 11'd0 || s_y !== 11'd0) begin errors++; $display("FAIL sm_sof_origin got (%0d,%0d) ok=%b want (0,0)", s_x, s_y, ok); end
        sof_cnt = 0; sof_pos = 0; hs_low = 0; vs_low = 0; bn_hi = 0;
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (s_sof) begin sof_cnt++; sof_pos = i; end
            if (!s_hs) hs_low++;
            if (!s_vs) vs_low++;
            if (s_bn) bn_hi++;
        end
        checks++;
        if (sof_cnt != 1 || sof_pos != 256) begin errors++; $display("FAIL sm_sof_period got cnt=%0d at=%0d want 1 at 256", sof_cnt, sof_pos); end
        checks++;
        if (hs_low != 48 || vs_low != 64 || bn_hi != 64) begin
            errors++; $display("FAIL sm_frame_counts got hs=%0d vs=%0d bn=%0d want 48,64,64", hs_low, vs_low, bn_hi);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        int bad;
        rgb = 8'hFF;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            tick();
            ok = (d_x == 11'd300);
        end
        checks++;
        if (!ok || d_bn !== 1'b1 || d_r !== 8'hFF) begin errors++; $display("FAIL pre_reset got bn=%b r=%h ok=%b want 1,ff", d_bn, d_r, ok); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({d_x, d_y, d_hs, d_vs, d_bn, d_sof, d_r, d_g, d_b} !== {22'd0, 4'b1100, 24'h0}) begin
            errors++; $display("FAIL async_reset got (%0d,%0d) hs/vs/bn/sof=%b%b%b%b rgb=%h want (0,0) 1100 000000",
                d_x, d_y, d_hs, d_vs, d_bn, d_sof, {d_r, d_g, d_b});
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (d_sof || s_sof || a_sof || b_sof || d_x != 11'd0 || !d_hs) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_hold got %0d bad clks want 0", bad); end
        reset = 1'b0;
        tick();
        checks++;
        if (d_x !== 11'd0 || a_x !== 11'd1 || d_sof !== 1'b0) begin errors++; $display("FAIL restart_edge1 got def x=%0d div1 x=%0d sof=%b want 0,1,0", d_x, a_x, d_sof); end
        tick();
        checks++;
        if (d_x !== 11'd1 || d_y !== 11'd0 || {d_hs, d_vs} !== 2'b11) begin
            errors++; $display("FAIL restart_edge2 got (%0d,%0d) hs/vs=%b%b want (1,0) 11", d_x, d_y, d_hs, d_vs);
        end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_wrap();
        test_pipe_lag();
        test_color();
        test_blank();
        test_hsync();
        test_frame();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
